// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use stall, forwarding select and flush controller
//
// Purpose: tracks the instructions in flight after ID in a DEPTH-entry scoreboard
//   (stage 0 = EX .. stage DEPTH-1 = WB). It selects the forwarding source for each
//   EX operand and stalls ID when the youngest producer of an operand is a load
//   whose data is not yet available.
//
// Parameters: DEPTH (3..8), LOAD_READY (1..DEPTH-1), REG_W.
// Ports:
//   clk, reset (async, active-low)
//   id_rs, id_rt, id_use_rs, id_use_rt  - ID source operands and their use bits
//   id_wr_en, id_is_load, id_dest       - ID destination information
//   id_redirect                         - control-flow redirect resolved in ID
//   pc_en, ifid_en, ifid_flush, bubble  - combinational pipeline controls
//   fwd_a_ex, fwd_b_ex, ex_valid        - registered EX-stage controls
//   stall_cnt, flush_cnt                - event counters
// Optional feature: define PIPE_HAZARD_STATS_EN to build the saturating event
//   counters; otherwise both counter outputs are tied to zero.
module pipe_hazard_ctrl #(
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int REG_W      = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [REG_W-1:0]           id_rs,
  input  logic [REG_W-1:0]           id_rt,
  input  logic                       id_use_rs,
  input  logic                       id_use_rt,
  input  logic                       id_wr_en,
  input  logic                       id_is_load,
  input  logic [REG_W-1:0]           id_dest,
  input  logic                       id_redirect,
  output logic                       pc_en,
  output logic                       ifid_en,
  output logic                       ifid_flush,
  output logic                       bubble,
  output logic [$clog2(DEPTH)-1:0]   fwd_a_ex,
  output logic [$clog2(DEPTH)-1:0]   fwd_b_ex,
  output logic                       ex_valid,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                flush_cnt
);

  localparam int FW = $clog2(DEPTH);

  logic             r_valid [DEPTH];
  logic             r_wr    [DEPTH];
  logic             r_ld    [DEPTH];
  logic [REG_W-1:0] r_dest  [DEPTH];

  logic          w_hit_a, w_hit_b;
  logic          w_rdy_a, w_rdy_b;
  logic [FW-1:0] w_sel_a, w_sel_b;
  logic          w_stall;

  // Scan from the oldest stage toward stage 0 so that the youngest matching
  // producer is the last one written and therefore wins. The WB stage is
  // skipped because the register file writes through.
  always_comb begin
    w_hit_a = 1'b0;
    w_hit_b = 1'b0;
    w_rdy_a = 1'b1;
    w_rdy_b = 1'b1;
    w_sel_a = '0;
    w_sel_b = '0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if ((s <= DEPTH - 2) && r_valid[s] && r_wr[s]) begin
        if (id_use_rs && (id_rs != '0) && (r_dest[s] == id_rs)) begin
          w_hit_a = 1'b1;
          w_sel_a = FW'(s + 1);
          w_rdy_a = !r_ld[s] || ((s + 1) >= LOAD_READY);
        end
        if (id_use_rt && (id_rt != '0) && (r_dest[s] == id_rt)) begin
          w_hit_b = 1'b1;
          w_sel_b = FW'(s + 1);
          w_rdy_b = !r_ld[s] || ((s + 1) >= LOAD_READY);
        end
      end
    end
  end

  assign w_stall    = (w_hit_a && !w_rdy_a) || (w_hit_b && !w_rdy_b);
  assign pc_en      = !w_stall;
  assign ifid_en    = !w_stall;
  assign bubble     = w_stall;
  // A redirect is held off while stalled; ID still holds the branch afterwards.
  assign ifid_flush = id_redirect && !w_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        r_valid[s] <= 1'b0;
        r_wr[s]    <= 1'b0;
        r_ld[s]    <= 1'b0;
        r_dest[s]  <= '0;
      end
      fwd_a_ex <= '0;
      fwd_b_ex <= '0;
      ex_valid <= 1'b0;
    end else begin
      for (int s = 1; s < DEPTH; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_wr[s]    <= r_wr[s-1];
        r_ld[s]    <= r_ld[s-1];
        r_dest[s]  <= r_dest[s-1];
      end
      if (w_stall) begin
        r_valid[0] <= 1'b0;
        r_wr[0]    <= 1'b0;
        r_ld[0]    <= 1'b0;
        r_dest[0]  <= '0;
        fwd_a_ex   <= '0;
        fwd_b_ex   <= '0;
        ex_valid   <= 1'b0;
      end else begin
        r_valid[0] <= 1'b1;
        r_wr[0]    <= id_wr_en;
        r_ld[0]    <= id_is_load;
        r_dest[0]  <= id_dest;
        fwd_a_ex   <= w_sel_a;
        fwd_b_ex   <= w_sel_b;
        ex_valid   <= 1'b1;
      end
    end
  end

`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (ifid_flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_use_rs, id_use_rt, id_wr_en, id_is_load, id_redirect;

  logic        pc_en3, ifid_en3, ifid_flush3, bubble3, exv3;
  logic [1:0]  fa3, fb3;
  logic [31:0] sc3, fc3;
  logic        pc_en5, ifid_en5, ifid_flush5, bubble5, exv5;
  logic [2:0]  fa5, fb5;
  logic [31:0] sc5, fc5;

  pipe_hazard_ctrl #(.DEPTH(3), .LOAD_READY(2), .REG_W(5)) u3 (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_dest(id_dest),
    .id_redirect(id_redirect),
    .pc_en(pc_en3), .ifid_en(ifid_en3), .ifid_flush(ifid_flush3), .bubble(bubble3),
    .fwd_a_ex(fa3), .fwd_b_ex(fb3), .ex_valid(exv3),
    .stall_cnt(sc3), .flush_cnt(fc3)
  );

  pipe_hazard_ctrl #(.DEPTH(5), .LOAD_READY(3), .REG_W(5)) u5 (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_dest(id_dest),
    .id_redirect(id_redirect),
    .pc_en(pc_en5), .ifid_en(ifid_en5), .ifid_flush(ifid_flush5), .bubble(bubble5),
    .fwd_a_ex(fa5), .fwd_b_ex(fb5), .ex_valid(exv5),
    .stall_cnt(sc5), .flush_cnt(fc5)
  );

`ifdef PIPE_HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_comb(input string name, input logic pc, input logic ie,
                            input logic bub, input logic fl, input bit e_stall, input bit e_flush);
    chk({name, "_pc_en"}, 32'(pc), 32'(!e_stall));
    chk({name, "_ifid_en"}, 32'(ie), 32'(!e_stall));
    chk({name, "_bubble"}, 32'(bub), 32'(e_stall));
    chk({name, "_flush"}, 32'(fl), 32'(e_flush));
  endtask

  // Reference model: every instruction that left ID is remembered with the edge
  // number at which it entered EX; its stage is simply the age in edges.
  typedef struct {
    int inst;
    int stamp;
    bit wr;
    bit ld;
    int dest;
  } ent_t;

  ent_t hist[$];
  int   ecount;
  int   es[2], ef[2];

  function automatic void find(input int inst, input int depth, input int src, input bit use_src,
                               output bit found, output int stage, output bit ld);
    found = 1'b0;
    stage = 0;
    ld    = 1'b0;
    if (!use_src || src == 0) return;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].inst == inst && hist[i].wr && hist[i].dest == src &&
          (ecount - hist[i].stamp) <= depth - 2) begin
        found = 1'b1;
        stage = ecount - hist[i].stamp;
        ld    = hist[i].ld;
        return;
      end
    end
  endfunction

  function automatic void predict(input int inst, input int depth, input int lr,
                                  output bit stall, output int fa, output int fb);
    bit fnd_a, fnd_b, ld_a, ld_b;
    int st_a, st_b;
    find(inst, depth, int'(id_rs), id_use_rs, fnd_a, st_a, ld_a);
    find(inst, depth, int'(id_rt), id_use_rt, fnd_b, st_b, ld_b);
    stall = (fnd_a && ld_a && (st_a + 1 < lr)) || (fnd_b && ld_b && (st_b + 1 < lr));
    fa = (stall || !fnd_a) ? 0 : st_a + 1;
    fb = (stall || !fnd_b) ? 0 : st_b + 1;
  endfunction

  task automatic set_in(input int rs, input int rt, input bit urs, input bit urt,
                        input bit wr, input bit ld, input int dest, input bit redir);
    id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
    id_wr_en = wr; id_is_load = ld; id_dest = 5'(dest); id_redirect = redir;
  endtask

  // Leaves the bench at a falling edge with reset released and model cleared.
  task automatic do_reset(input string name);
    @(negedge clk);
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    check_comb({name, "_u3"}, pc_en3, ifid_en3, bubble3, ifid_flush3, 1'b0, 1'b1);
    check_comb({name, "_u5"}, pc_en5, ifid_en5, bubble5, ifid_flush5, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk({name, "_fa3"}, 32'(fa3), 0);
    chk({name, "_fb3"}, 32'(fb3), 0);
    chk({name, "_exv3"}, 32'(exv3), 0);
    chk({name, "_sc3"}, sc3, 0);
    chk({name, "_fc3"}, fc3, 0);
    chk({name, "_fa5"}, 32'(fa5), 0);
    chk({name, "_exv5"}, 32'(exv5), 0);
    @(negedge clk);
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    hist.delete();
    ecount = 0;
    es[0] = 0; es[1] = 0; ef[0] = 0; ef[1] = 0;
  endtask

  typedef struct {
    int rs, rt;
    bit urs, urt, wr, ld;
    int dest;
    bit redir;
    bit e_stall, e_flush;
    int e_fa, e_fb;
    bit e_exv;
  } vec_t;

  function automatic vec_t mk(input int rs, input int rt, input bit urs, input bit urt,
                              input bit wr, input bit ld, input int dest, input bit redir,
                              input bit st, input bit fl, input int fa, input int fb, input bit exv);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.wr = wr; v.ld = ld;
    v.dest = dest; v.redir = redir; v.e_stall = st; v.e_flush = fl;
    v.e_fa = fa; v.e_fb = fb; v.e_exv = exv;
    return v;
  endfunction

  localparam int NV = 30;
  vec_t tbl [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bit st[2];
    int ea[2], eb[2];

    //              rs  rt urs urt wr ld dst rd   st fl fa fb exv
    tbl[0]  = mk(   0,  0, 0, 0, 1, 1,  8, 0,   0, 0, 0, 0, 1);  // load r8
    tbl[1]  = mk(   8,  0, 1, 0, 0, 0,  0, 0,   1, 0, 0, 0, 0);  // load-use stall
    tbl[2]  = mk(   8,  0, 1, 0, 0, 0,  0, 0,   0, 0, 2, 0, 1);  // forward from stage 2
    tbl[3]  = mk(   0,  0, 0, 0, 1, 0,  9, 0,   0, 0, 0, 0, 1);  // alu r9
    tbl[4]  = mk(   0,  9, 0, 1, 0, 0,  0, 0,   0, 0, 0, 1, 1);  // direct use -> 1
    tbl[5]  = mk(   0,  0, 0, 0, 1, 0,  9, 0,   0, 0, 0, 0, 1);  // alu r9
    tbl[6]  = mk(   0,  0, 0, 0, 1, 0,  3, 0,   0, 0, 0, 0, 1);  // unrelated
    tbl[7]  = mk(   0,  9, 0, 1, 0, 0,  0, 0,   0, 0, 0, 2, 1);  // gap of one -> 2
    tbl[8]  = mk(   0,  0, 0, 0, 1, 0, 10, 0,   0, 0, 0, 0, 1);  // r10 older
    tbl[9]  = mk(   0,  0, 0, 0, 1, 0, 10, 0,   0, 0, 0, 0, 1);  // r10 younger
    tbl[10] = mk(  10, 10, 1, 1, 0, 0,  0, 0,   0, 0, 1, 1, 1);  // youngest wins
    tbl[11] = mk(   0,  0, 0, 0, 1, 0,  0, 0,   0, 0, 0, 0, 1);  // alu r0
    tbl[12] = mk(   0,  0, 1, 1, 1, 1,  0, 0,   0, 0, 0, 0, 1);  // r0 use, load r0
    tbl[13] = mk(   0,  0, 1, 0, 0, 0,  0, 0,   0, 0, 0, 0, 1);  // r0 after load r0
    tbl[14] = mk(   0,  0, 0, 0, 1, 1,  8, 0,   0, 0, 0, 0, 1);  // load r8
    tbl[15] = mk(   8,  0, 1, 0, 0, 0,  0, 1,   1, 0, 0, 0, 0);  // redirect held off
    tbl[16] = mk(   8,  0, 1, 0, 0, 0,  0, 1,   0, 1, 2, 0, 1);  // redirect flushes
    tbl[17] = mk(   0,  0, 0, 0, 1, 1,  5, 0,   0, 0, 0, 0, 1);  // load r5
    tbl[18] = mk(   0,  0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 1);
    tbl[19] = mk(   0,  0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 1);
    tbl[20] = mk(   5,  0, 1, 0, 0, 0,  0, 0,   0, 0, 0, 0, 1);  // producer in WB
    tbl[21] = mk(   0,  0, 0, 0, 1, 0,  7, 0,   0, 0, 0, 0, 1);  // alu r7
    tbl[22] = mk(   7,  7, 0, 1, 0, 0,  0, 0,   0, 0, 0, 1, 1);  // rs not used
    tbl[23] = mk(   0,  0, 0, 0, 1, 0, 11, 0,   0, 0, 0, 0, 1);  // alu r11
    tbl[24] = mk(   0,  0, 0, 0, 1, 1, 11, 0,   0, 0, 0, 0, 1);  // load r11
    tbl[25] = mk(  11,  0, 1, 0, 0, 0,  0, 0,   1, 0, 0, 0, 0);  // younger load stalls
    tbl[26] = mk(  11,  0, 1, 0, 0, 0,  0, 0,   0, 0, 2, 0, 1);
    tbl[27] = mk(   0,  0, 0, 0, 1, 1,  6, 0,   0, 0, 0, 0, 1);  // load r6
    tbl[28] = mk(   0,  6, 0, 1, 0, 0,  0, 0,   1, 0, 0, 0, 0);  // rt load-use
    tbl[29] = mk(   0,  6, 0, 1, 0, 0,  0, 0,   0, 0, 0, 2, 1);

    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset("rst0");

    for (int i = 0; i < NV; i++) begin
      set_in(tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].wr, tbl[i].ld,
             tbl[i].dest, tbl[i].redir);
      #1;
      check_comb($sformatf("tbl%0d", i), pc_en3, ifid_en3, bubble3, ifid_flush3,
                 tbl[i].e_stall, tbl[i].e_flush);
      @(posedge clk); #1;
      if (STATS) begin
        es[0] += int'(tbl[i].e_stall);
        ef[0] += int'(tbl[i].e_flush);
      end
      chk($sformatf("tbl%0d_fa", i), 32'(fa3), tbl[i].e_fa);
      chk($sformatf("tbl%0d_fb", i), 32'(fb3), tbl[i].e_fb);
      chk($sformatf("tbl%0d_exv", i), 32'(exv3), 32'(tbl[i].e_exv));
      chk($sformatf("tbl%0d_scnt", i), sc3, es[0]);
      chk($sformatf("tbl%0d_fcnt", i), fc3, ef[0]);
      @(negedge clk);
    end

    // DEPTH=5, LOAD_READY=3: two stall cycles, then forward from stage 3.
    do_reset("rst1");
    set_in(0, 0, 0, 0, 1, 1, 8, 0);
    @(posedge clk); #1;
    @(negedge clk);
    set_in(8, 0, 1, 0, 0, 0, 0, 0);
    #1;
    check_comb("d5_st1", pc_en5, ifid_en5, bubble5, ifid_flush5, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("d5_st1_exv", 32'(exv5), 0);
    @(negedge clk); #1;
    check_comb("d5_st2", pc_en5, ifid_en5, bubble5, ifid_flush5, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check_comb("d5_go", pc_en5, ifid_en5, bubble5, ifid_flush5, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("d5_fa", 32'(fa5), 3);
    chk("d5_exv", 32'(exv5), 1);

    // Reset asserted in the first stall cycle releases the stall at once.
    do_reset("rst2");
    set_in(0, 0, 0, 0, 1, 1, 8, 0);
    @(posedge clk); #1;
    @(negedge clk);
    set_in(8, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("mid_pre_pc5", 32'(pc_en5), 0);
    chk("mid_pre_pc3", 32'(pc_en3), 0);
    reset = 1'b0;
    #1;
    check_comb("mid_rst5", pc_en5, ifid_en5, bubble5, ifid_flush5, 1'b0, 1'b0);
    check_comb("mid_rst3", pc_en3, ifid_en3, bubble3, ifid_flush3, 1'b0, 1'b0);
    chk("mid_rst_exv5", 32'(exv5), 0);

    // Randomized traffic on both configurations against the reference model.
    do_reset("rst3");
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
             $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      #1;
      predict(0, 3, 2, st[0], ea[0], eb[0]);
      predict(1, 5, 3, st[1], ea[1], eb[1]);
      check_comb($sformatf("rnd%0d_u3", c), pc_en3, ifid_en3, bubble3, ifid_flush3,
                 st[0], id_redirect && !st[0]);
      check_comb($sformatf("rnd%0d_u5", c), pc_en5, ifid_en5, bubble5, ifid_flush5,
                 st[1], id_redirect && !st[1]);
      @(posedge clk); #1;
      ecount++;
      for (int k = 0; k < 2; k++) begin
        if (!st[k]) hist.push_back('{k, ecount, id_wr_en, id_is_load, int'(id_dest)});
        if (STATS) begin
          es[k] += int'(st[k]);
          ef[k] += int'(id_redirect && !st[k]);
        end
      end
      chk($sformatf("rnd%0d_fa3", c), 32'(fa3), ea[0]);
      chk($sformatf("rnd%0d_fb3", c), 32'(fb3), eb[0]);
      chk($sformatf("rnd%0d_exv3", c), 32'(exv3), 32'(!st[0]));
      chk($sformatf("rnd%0d_fa5", c), 32'(fa5), ea[1]);
      chk($sformatf("rnd%0d_fb5", c), 32'(fb5), eb[1]);
      chk($sformatf("rnd%0d_exv5", c), 32'(exv5), 32'(!st[1]));
      chk($sformatf("rnd%0d_sc3", c), sc3, es[0]);
      chk($sformatf("rnd%0d_fc3", c), fc3, ef[0]);
      chk($sformatf("rnd%0d_sc5", c), sc5, es[1]);
      chk($sformatf("rnd%0d_fc5", c), fc5, ef[1]);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 3, giving the number of tracked stages after ID: stage 0 = EX, stage DEPTH-1 = WB, legal range 3..8.
REQ-002 SHALL have parameter LOAD_READY, default 2, giving the stage index at which load data becomes forwardable; legal range 1..DEPTH-1.
REQ-003 SHALL have parameter REG_W, default 5, giving the register address width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 id_rs, id_rt  input  REG_W each  source registers of the instruction in ID.
REQ-007 id_use_rs, id_use_rt  input  1 each  the ID instruction reads rs / rt.
REQ-008 id_wr_en, id_is_load  input  1 each  the ID instruction writes a register / is a load.
REQ-009 id_dest  input  REG_W  destination register of the ID instruction.
REQ-010 id_redirect  input  1  branch taken, jump or jr resolved in ID this cycle.
REQ-011 pc_en, ifid_en  output  1 each  PC and IF/ID register load enables.
REQ-012 ifid_flush  output  1  clear IF/ID on the next edge.
REQ-013 bubble  output  1  insert all-zero control signals into ID/EX.
REQ-014 fwd_a_ex, fwd_b_ex  output  $clog2(DEPTH) each  registered forward selects for the EX operands: 0 = register file value, k = value from stage k.
REQ-015 ex_valid  output  1  EX holds a real instruction, not a bubble.
REQ-016 stall_cnt, flush_cnt  output  32 each  event counters (see Configuration).

Function
REQ-017 SHALL keep a scoreboard shift register of DEPTH entries {valid, wr_en, is_load, dest} that advances one stage every cycle; entry DEPTH-1 is discarded.
REQ-018 A producer SHALL match a source if valid, wr_en, dest==src, src!=0, the source's use bit is set, and the producer sits in stage 0..DEPTH-2.
REQ-019 When several producers match, the youngest (lowest stage index) SHALL win.
REQ-020 Readiness SHALL be: a producer now at stage s is ready if s+1 >= LOAD_READY for loads, and always ready for non-loads.
REQ-021 A winning producer that is not ready SHALL raise stall combinationally in the same cycle.
REQ-022 On stall: pc_en=0, ifid_en=0, bubble=1; entry 0 loads invalid; fwd selects load 0; ex_valid loads 0.
REQ-023 Without stall: pc_en=ifid_en=1, bubble=0; entry 0 loads the ID instruction; ex_valid loads 1.
REQ-024 Without stall, each fwd select SHALL load s+1 of the winning producer, or 0 if no producer matches.
REQ-025 ifid_flush SHALL equal id_redirect AND NOT stall; stall takes priority, so a redirect during a stall is ignored until the stall clears.
REQ-026 A producer in stage DEPTH-1 SHALL never cause forwarding or a stall; the register file is write-through.
REQ-027 Register 0 SHALL never match, whatever the wr_en setting.
REQ-028 Stall, pc_en, ifid_en, bubble and ifid_flush SHALL be combinational; fwd_a_ex, fwd_b_ex and ex_valid SHALL be registered, with 1-cycle latency.

Reset
REQ-029 While reset=0: every scoreboard entry is invalid, fwd_a_ex=fwd_b_ex=0, ex_valid=0, and counters are 0.
REQ-030 Because the scoreboard is empty in reset, stall=0, so pc_en=ifid_en=1, bubble=0 and ifid_flush=id_redirect.
REQ-031 Reset asserted mid-stall SHALL clear the stall immediately (asynchronously).

Configuration
REQ-032 With macro PIPE_HAZARD_STATS_EN defined, stall_cnt SHALL increment on every stall cycle and flush_cnt on every ifid_flush cycle, both saturating at 32'hFFFFFFFF.
REQ-033 Without PIPE_HAZARD_STATS_EN, both counters SHALL be constant 0 and no counter flops SHALL be synthesised.

Verification
REQ-034 DEPTH=3, LOAD_READY=2: load r8 in ID, next cycle a consumer of rs=r8 -> exactly 1 stall cycle (pc_en=0, bubble=1), then fwd_a_ex=2 on the following edge.
REQ-035 ALU writer of r9 followed directly by a consumer of rt=r9 -> no stall, fwd_b_ex=1; with one unrelated instruction in between -> fwd_b_ex=2.
REQ-036 Two in-flight writers of r10 at stages 0 and 1, consumer in ID -> fwd_a_ex=1 (youngest producer wins).
REQ-037 Writer of r0 followed by a consumer of r0 -> fwd_a_ex=0 and no stall.
REQ-038 id_redirect=1 together with a load-use stall -> ifid_flush=0; once the stall clears with id_redirect still 1 -> ifid_flush=1, and flush_cnt increments by 1 when PIPE_HAZARD_STATS_EN is defined.
REQ-039 DEPTH=5, LOAD_READY=3, load followed by a consumer -> 2 stall cycles, then fwd select=3; reset asserted during the first stall cycle -> pc_en=1 immediately.
